maze_mem_arbiter: RTL and testbench
===================================

MAZE_MEM_ARBITER -- requirements
Module: maze_mem_arbiter

Interface
REQ-001 SHALL have parameter LOCK_MAX, default 8, meaning the maximum number of consecutive locked game cycles before a forced release.
REQ-002 SHALL have parameter WAIT_MAX, default 16, meaning the display wait limit in cycles before it wins arbitration.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Ports: clk  input  1  system clock, 50 MHz.
REQ-005 Ports: nrst  input  1  asynchronous active-low reset.
REQ-006 Ports: disp_req  input  1  display read request; disp_addr  input  6  display cell address.
REQ-007 Ports: disp_gnt  output  1  display granted this cycle; disp_rdata  output  2  display read data; disp_valid  output  1  display rdata valid.
REQ-008 Ports: game_req  input  1  game request; game_we  input  1  game write enable; game_addr  input  6  game address; game_wdata  input  2  game write data; game_lock  input  1  hold grant for read-modify-write.
REQ-009 Ports: game_gnt  output  1  game granted; game_rdata  output  2  game read data; game_valid  output  1  game rdata valid; lock_abort  output  1  forced-release pulse.
REQ-010 Ports: mem_addr  output  6  memory address; mem_we  output  1  memory write; mem_wdata  output  2  memory write data; mem_rdata  input  2  memory read data, 1-cycle latency.

Function
REQ-011 SHALL use states ARB and LOCKED.
REQ-012 SHALL assert at most one of disp_gnt/game_gnt per cycle; grants are combinational from the req inputs and registered state.
REQ-013 SHALL drive mem_addr/mem_we/mem_wdata combinationally from the granted requester; the display always drives mem_we=0.
REQ-014 With no grant, SHALL drive mem_we=0 and hold mem_addr at the last granted address.
REQ-015 SHALL pulse the granted requester's valid one cycle after a read grant (we=0), with rdata=mem_rdata; game writes produce no game_valid.
REQ-016 SHALL hold rdata outputs between valid pulses.
REQ-017 In ARB with both requesting, SHALL apply the base priority (REQ-027/028), except that the display wins when disp_wait >= WAIT_MAX.
REQ-018 disp_wait SHALL count cycles with disp_req high and disp_gnt low, saturate at WAIT_MAX, and clear on a display grant or when disp_req is low.
REQ-019 SHALL move ARB->LOCKED when game_gnt and game_lock are both high.
REQ-020 In LOCKED, SHALL grant only the game, and only while game_req=1; disp_req is ignored and disp_wait keeps counting.
REQ-021 SHALL move LOCKED->ARB on the cycle after game_lock falls.
REQ-022 lock_cnt SHALL count LOCKED cycles.
REQ-023 When lock_cnt reaches LOCK_MAX, SHALL force LOCKED->ARB, pulse lock_abort for 1 cycle and give the next ARB cycle to the display if it is requesting.
REQ-024 After a forced release, SHALL not re-lock until game_lock has been seen low.
REQ-025 A simultaneous lock release and LOCK_MAX SHALL count as a normal release with no lock_abort.

Reset
REQ-026 nrst low SHALL immediately clear both gnt outputs (grants are combinational from the cleared state), disp_valid/game_valid/lock_abort=0, rdata=0, mem_we=0, mem_addr=0, state=ARB, counters=0 and the round-robin pointer to display-next; an in-flight read's valid is dropped.

Configuration
REQ-027 With ARB_ROUND_ROBIN_EN defined, SHALL grant the requester not granted most recently when both request in ARB, with WAIT_MAX override still active.
REQ-028 Without ARB_ROUND_ROBIN_EN, SHALL use fixed priority with the game over the display, subject to the WAIT_MAX override.

Verification
REQ-029 Display-only read, disp_addr=6'd10, mem_rdata=2'b10 -> disp_gnt same cycle, disp_valid next cycle, disp_rdata=2'b10.
REQ-030 Fixed priority, both request continuously -> game granted for 16 cycles, display granted on cycle 17.
REQ-031 Round robin, both request continuously -> grants alternate game/display each cycle.
REQ-032 Game lock with RMW addr 6'd5, read then write 2'b11 over 3 cycles, display requesting -> no disp_gnt until the cycle after game_lock falls; mem_we=1 with mem_wdata=2'b11 on the write cycle.
REQ-033 game_lock held 20 cycles -> lock_abort pulses once at lock cycle 8; the display is granted next; no relock until game_lock goes low.
REQ-034 nrst asserted one cycle after a read grant -> no valid pulse and all outputs at reset values.

Source files
------------

// File: rtl/maze_mem_arbiter.sv
// maze_mem_arbiter: two-requester arbiter for the shared maze cell memory.
//
// The display reads cells; the game reads and writes them and may hold the
// memory with game_lock for a read-modify-write. The display gets a
// starvation override after WAIT_MAX waiting cycles, and a game lock is
// broken after LOCK_MAX cycles.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : round-robin between the requesters when both ask in ARB
//   undefined : fixed priority, game over display (default build)
//
// Ports
//   clk, nrst                    clock, asynchronous active-low reset
//   disp_req/disp_addr           display read request and cell address
//   disp_gnt                     display granted this cycle (combinational)
//   disp_rdata/disp_valid        display read data, valid one cycle after grant
//   game_req/we/addr/wdata/lock  game request, write, lock for RMW
//   game_gnt                     game granted this cycle (combinational)
//   game_rdata/game_valid        game read data, valid one cycle after read grant
//   lock_abort                   one-cycle pulse on a forced lock release
//   mem_addr/mem_we/mem_wdata    memory command, driven from the granted side
//   mem_rdata                    memory read data, one cycle after the address
module maze_mem_arbiter #(
    parameter int unsigned LOCK_MAX = 8,
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       disp_req,
    input  logic [5:0] disp_addr,
    output logic       disp_gnt,
    output logic [1:0] disp_rdata,
    output logic       disp_valid,
    input  logic       game_req,
    input  logic       game_we,
    input  logic [5:0] game_addr,
    input  logic [1:0] game_wdata,
    input  logic       game_lock,
    output logic       game_gnt,
    output logic [1:0] game_rdata,
    output logic       game_valid,
    output logic       lock_abort,
    output logic [5:0] mem_addr,
    output logic       mem_we,
    output logic [1:0] mem_wdata,
    input  logic [1:0] mem_rdata
);

    localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);
    localparam int unsigned LOCK_W = $clog2(LOCK_MAX + 1);

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   disp_wait_q, disp_wait_d;
    logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d, lock_cnt_inc;
    logic                force_disp_q, force_disp_d;
    logic                no_relock_q, no_relock_d;
    logic                lock_abort_q, lock_abort_d;
    logic                starved, disp_win;
    logic                disp_gnt_c, game_gnt_c;
    logic [5:0]          last_addr_q, mem_addr_c;
    logic                disp_valid_q, game_valid_q;
    logic [1:0]          disp_hold_q, game_hold_q;
`ifdef ARB_ROUND_ROBIN_EN
    logic                rr_disp_q;
`endif

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, grants, lock/wait bookkeeping
    always_comb begin
        state_d      = state_q;
        disp_win     = 1'b0;
        disp_gnt_c   = 1'b0;
        game_gnt_c   = 1'b0;
        lock_cnt_inc = lock_cnt_q + LOCK_W'(1);
        lock_cnt_d   = '0;
        force_disp_d = force_disp_q;
        no_relock_d  = no_relock_q & game_lock;
        lock_abort_d = 1'b0;
        starved      = (disp_wait_q >= WAIT_W'(WAIT_MAX));
        disp_wait_d  = '0;

        unique case (state_q)
            ARB: begin
                // A forced release owes the display this one ARB cycle
                force_disp_d = 1'b0;
                if (force_disp_q && disp_req) begin
                    disp_win = 1'b1;
                end else if (disp_req && game_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                    disp_win = starved | rr_disp_q;
`else
                    disp_win = starved;
`endif
                end else begin
                    disp_win = disp_req;
                end
                disp_gnt_c = disp_win;
                game_gnt_c = game_req & ~disp_win;
                if (game_gnt_c && game_lock && !no_relock_q) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                game_gnt_c = game_req;
                // Lock dropping on the last allowed cycle is a normal release
                if (!game_lock) begin
                    state_d = ARB;
                end else if (lock_cnt_inc == LOCK_W'(LOCK_MAX)) begin
                    state_d      = ARB;
                    lock_abort_d = 1'b1;
                    force_disp_d = 1'b1;
                    no_relock_d  = 1'b1;
                end else begin
                    lock_cnt_d = lock_cnt_inc;
                end
            end
            default: state_d = ARB;
        endcase

        // Display starvation counter, saturating
        if (disp_req && !disp_gnt_c) begin
            disp_wait_d = starved ? disp_wait_q : disp_wait_q + WAIT_W'(1);
        end
    end

    // Grants are forced low while reset is held
    assign disp_gnt = disp_gnt_c & nrst;
    assign game_gnt = game_gnt_c & nrst;

    // Memory command follows the granted requester, else holds last address
    assign mem_addr_c = disp_gnt_c ? disp_addr : (game_gnt_c ? game_addr : last_addr_q);
    assign mem_addr   = disp_gnt ? disp_addr : (game_gnt ? game_addr : last_addr_q);
    assign mem_we     = game_gnt & game_we;
    assign mem_wdata  = game_gnt ? game_wdata : 2'b00;

    // Read data is live on the valid cycle and held afterwards
    assign disp_valid = disp_valid_q;
    assign game_valid = game_valid_q;
    assign disp_rdata = disp_valid_q ? mem_rdata : disp_hold_q;
    assign game_rdata = game_valid_q ? mem_rdata : game_hold_q;
    assign lock_abort = lock_abort_q;

    // Datapath and bookkeeping registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            disp_wait_q  <= '0;
            lock_cnt_q   <= '0;
            force_disp_q <= 1'b0;
            no_relock_q  <= 1'b0;
            lock_abort_q <= 1'b0;
            last_addr_q  <= '0;
            disp_valid_q <= 1'b0;
            game_valid_q <= 1'b0;
            disp_hold_q  <= '0;
            game_hold_q  <= '0;
        end else begin
            disp_wait_q  <= disp_wait_d;
            lock_cnt_q   <= lock_cnt_d;
            force_disp_q <= force_disp_d;
            no_relock_q  <= no_relock_d;
            lock_abort_q <= lock_abort_d;
            last_addr_q  <= mem_addr_c;
            disp_valid_q <= disp_gnt_c;
            game_valid_q <= game_gnt_c & ~game_we;
            if (disp_valid_q) begin
                disp_hold_q <= mem_rdata;
            end
            if (game_valid_q) begin
                game_hold_q <= mem_rdata;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Round-robin pointer: favour whoever was not granted last
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rr_disp_q <= 1'b1;
        end else if (disp_gnt_c) begin
            rr_disp_q <= 1'b0;
        end else if (game_gnt_c) begin
            rr_disp_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Testbench for maze_mem_arbiter: directed vectors, a behavioural model
// checked every cycle, and literal expectations at key points.
module tb_maze_mem_arbiter;

    localparam int unsigned LM = 8;
    localparam int unsigned WM = 16;

    logic       clk;
    logic       nrst;
    logic       disp_req;
    logic [5:0] disp_addr;
    logic       disp_gnt;
    logic [1:0] disp_rdata;
    logic       disp_valid;
    logic       game_req;
    logic       game_we;
    logic [5:0] game_addr;
    logic [1:0] game_wdata;
    logic       game_lock;
    logic       game_gnt;
    logic [1:0] game_rdata;
    logic       game_valid;
    logic       lock_abort;
    logic [5:0] mem_addr;
    logic       mem_we;
    logic [1:0] mem_wdata;
    logic [1:0] mem_rdata;

    maze_mem_arbiter #(.LOCK_MAX(LM), .WAIT_MAX(WM)) dut (
        .clk(clk), .nrst(nrst),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rdata(disp_rdata), .disp_valid(disp_valid),
        .game_req(game_req), .game_we(game_we), .game_addr(game_addr),
        .game_wdata(game_wdata), .game_lock(game_lock), .game_gnt(game_gnt),
        .game_rdata(game_rdata), .game_valid(game_valid), .lock_abort(lock_abort),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Bench memory: unwritten cells read as the low two address bits
    bit [1:0] tb_mem [64];
    bit       tb_wr  [64];
    always @(posedge clk) begin
        if (mem_we) begin
            tb_mem[mem_addr] <= mem_wdata;
            tb_wr[mem_addr]  <= 1'b1;
        end
        mem_rdata <= tb_wr[mem_addr] ? tb_mem[mem_addr] : mem_addr[1:0];
    end

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // Model state
    bit [1:0] sh_mem [64];
    bit       sh_wr  [64];
    bit       m_locked, m_force, m_norelock, m_rr_disp, m_abort, m_dv, m_gv;
    int       m_wait, m_lcnt;
    logic [1:0] m_dpend, m_gpend, m_dhold, m_ghold;
    logic [5:0] m_last;
    bit       e_dg, e_gg;
    logic [5:0] e_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] sh_read(input logic [5:0] a);
        return sh_wr[a] ? sh_mem[a] : a[1:0];
    endfunction

    task automatic mdl_reset();
        m_locked = 0; m_force = 0; m_norelock = 0; m_rr_disp = 1; m_abort = 0;
        m_dv = 0; m_gv = 0; m_wait = 0; m_lcnt = 0;
        m_dpend = 0; m_gpend = 0; m_dhold = 0; m_ghold = 0; m_last = 0;
    endtask

    // Who must own the memory this cycle, from the arbitration rules
    task automatic mdl_compute();
        bit pref_disp;
`ifdef ARB_ROUND_ROBIN_EN
        pref_disp = m_rr_disp;
`else
        pref_disp = 1'b0;
`endif
        if (!nrst) begin
            e_dg = 0; e_gg = 0;
        end else if (m_locked) begin
            e_dg = 0; e_gg = game_req;
        end else begin
            if (m_force && disp_req)         e_dg = 1;
            else if (disp_req && game_req)   e_dg = (m_wait >= int'(WM)) || pref_disp;
            else                             e_dg = disp_req;
            e_gg = game_req && !e_dg;
        end
        e_addr = e_dg ? disp_addr : (e_gg ? game_addr : m_last);
    endtask

    task automatic mdl_compare();
        if (!nrst) mdl_reset();
        mdl_compute();
        chk("disp_gnt", disp_gnt, e_dg);
        chk("game_gnt", game_gnt, e_gg);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_we", mem_we, e_gg && game_we);
        if (e_gg && game_we) chk("mem_wdata", mem_wdata, game_wdata);
        chk("disp_valid", disp_valid, m_dv);
        chk("game_valid", game_valid, m_gv);
        chk("disp_rdata", disp_rdata, m_dv ? m_dpend : m_dhold);
        chk("game_rdata", game_rdata, m_gv ? m_gpend : m_ghold);
        chk("lock_abort", lock_abort, m_abort);
    endtask

    // Advance the model by one clock
    task automatic mdl_update();
        if (disp_req && !e_dg) m_wait = (m_wait + 1 > int'(WM)) ? int'(WM) : m_wait + 1;
        else                   m_wait = 0;
        if (m_dv) m_dhold = m_dpend;
        if (m_gv) m_ghold = m_gpend;
        m_dv = e_dg;
        if (e_dg) m_dpend = sh_read(disp_addr);
        m_gv = e_gg && !game_we;
        if (m_gv) m_gpend = sh_read(game_addr);
        if (e_gg && game_we) begin
            sh_mem[game_addr] = game_wdata;
            sh_wr[game_addr]  = 1'b1;
        end
        m_last = e_addr;
        if (e_dg) m_rr_disp = 0;
        else if (e_gg) m_rr_disp = 1;
        m_abort = 0;
        if (!game_lock) m_norelock = 0;
        if (m_locked) begin
            m_lcnt++;
            if (!game_lock) begin
                m_locked = 0; m_lcnt = 0;
            end else if (m_lcnt == int'(LM)) begin
                m_locked = 0; m_lcnt = 0; m_abort = 1; m_force = 1; m_norelock = 1;
            end
        end else begin
            m_force = 0;
            if (e_gg && game_lock && !m_norelock) begin
                m_locked = 1; m_lcnt = 0;
            end
        end
    endtask

    // One cycle: update model at posedge, drive at negedge, compare shortly after
    task automatic drive(input bit rn, input bit dr, input logic [5:0] da, input bit gr,
                         input bit gw, input logic [5:0] ga, input logic [1:0] gd, input bit gl);
        if (started) begin
            @(posedge clk);
            if (nrst) mdl_update();
        end
        @(negedge clk);
        nrst = rn; disp_req = dr; disp_addr = da; game_req = gr;
        game_we = gw; game_addr = ga; game_wdata = gd; game_lock = gl;
        started = 1'b1;
        #2;
        mdl_compare();
    endtask

    task automatic idle();
        drive(1, 0, 6'd0, 0, 0, 6'd0, 2'b00, 0);
    endtask

    initial begin
        int first_disp;
        int aborts;
        nrst = 0; disp_req = 0; disp_addr = 0; game_req = 0; game_we = 0;
        game_addr = 0; game_wdata = 0; game_lock = 0;

        // Reset with the display requesting: no grant may escape
        drive(0, 1, 6'd10, 0, 0, 6'd0, 2'b00, 0);
        chk("rst_disp_gnt", disp_gnt, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_disp_valid", disp_valid, 0);
        drive(0, 0, 6'd0, 0, 0, 6'd0, 2'b00, 0);
        idle();

        // Display-only read of cell 10
        drive(1, 1, 6'd10, 0, 0, 6'd0, 2'b00, 0);
        chk("d10_gnt", disp_gnt, 1);
        chk("d10_addr", mem_addr, 6'd10);
        idle();
        chk("d10_valid", disp_valid, 1);
        chk("d10_rdata", disp_rdata, 2'b10);
        idle();
        chk("d10_valid_end", disp_valid, 0);
        chk("d10_hold", disp_rdata, 2'b10);
        chk("hold_addr", mem_addr, 6'd10);

        // Game write then read back
        drive(1, 0, 6'd0, 1, 1, 6'd3, 2'b01, 0);
        chk("gw_we", mem_we, 1);
        idle();
        chk("gw_no_valid", game_valid, 0);
        drive(1, 0, 6'd0, 1, 0, 6'd3, 2'b00, 0);
        idle();
        chk("gr_valid", game_valid, 1);
        chk("gr_rdata", game_rdata, 2'b01);

`ifndef ARB_ROUND_ROBIN_EN
        // Fixed priority: display wins only after WAIT_MAX cycles of waiting
        first_disp = 0;
        for (int c = 1; c <= 17; c++) begin
            drive(1, 1, 6'd20, 1, 0, 6'd21, 2'b00, 0);
            if (disp_gnt && first_disp == 0) first_disp = c;
            if (c == 16) chk("fp_c16_game", game_gnt, 1);
        end
        chk("fp_first_disp_cycle", first_disp, 17);
`else
        // Round robin: display first (game was granted last), then alternate
        for (int c = 1; c <= 8; c++) begin
            drive(1, 1, 6'd20, 1, 0, 6'd21, 2'b00, 0);
            chk("rr_game", game_gnt, (c % 2) == 0);
        end
`endif
        idle();
        idle();

        // Locked RMW on cell 5 with the display queued
        drive(1, 0, 6'd0, 1, 0, 6'd5, 2'b00, 1);
        chk("rmw_rd_gnt", game_gnt, 1);
        drive(1, 1, 6'd9, 1, 1, 6'd5, 2'b11, 1);
        chk("rmw_wr_nodisp", disp_gnt, 0);
        chk("rmw_wr_we", mem_we, 1);
        chk("rmw_wr_data", mem_wdata, 2'b11);
        chk("rmw_rd_data", game_rdata, 2'b01);
        drive(1, 1, 6'd9, 0, 0, 6'd0, 2'b00, 0);
        chk("rmw_fall_nodisp", disp_gnt, 0);
        drive(1, 1, 6'd9, 0, 0, 6'd0, 2'b00, 0);
        chk("rmw_after_disp", disp_gnt, 1);
        idle();
        drive(1, 0, 6'd0, 1, 0, 6'd5, 2'b00, 0);
        idle();
        chk("rmw_readback", game_rdata, 2'b11);

        // Lock held too long: forced release, display served, no relock
        aborts = 0;
        for (int c = 1; c <= 20; c++) begin
            drive(1, c >= 2, 6'd12, c < 20, 0, 6'd7, 2'b00, 1);
            if (lock_abort) aborts++;
            if (c == 10) begin
                chk("abort_pulse", lock_abort, 1);
                chk("abort_disp", disp_gnt, 1);
            end
            if (c == 11) chk("abort_once", lock_abort, 0);
            if (c == 20) chk("no_relock", disp_gnt, 1);
        end
        chk("abort_count", aborts, 1);
        idle();
        drive(1, 0, 6'd0, 1, 0, 6'd7, 2'b00, 1);
        drive(1, 1, 6'd12, 0, 0, 6'd0, 2'b00, 1);
        chk("relock_ok", disp_gnt, 0);
        drive(1, 1, 6'd12, 0, 0, 6'd0, 2'b00, 0);
        chk("relock_fall", disp_gnt, 0);
        drive(1, 1, 6'd12, 0, 0, 6'd0, 2'b00, 0);
        chk("relock_release", disp_gnt, 1);
        idle();

        // Lock dropped on the LOCK_MAX-th locked cycle: normal release
        drive(1, 0, 6'd0, 1, 0, 6'd8, 2'b00, 1);
        for (int c = 1; c <= 7; c++) drive(1, 0, 6'd0, 1, 0, 6'd8, 2'b00, 1);
        drive(1, 0, 6'd0, 1, 0, 6'd8, 2'b00, 0);
        chk("sim_rel_abort", lock_abort, 0);
        drive(1, 1, 6'd2, 1, 0, 6'd8, 2'b00, 1);
        chk("sim_rel_no_abort", lock_abort, 0);
`ifndef ARB_ROUND_ROBIN_EN
        chk("sim_rel_game", game_gnt, 1);
        drive(1, 1, 6'd2, 0, 0, 6'd0, 2'b00, 0);
        chk("sim_rel_relocked", disp_gnt, 0);
`endif
        idle();
        idle();

        // Reset one cycle after a read grant drops the valid
        drive(1, 1, 6'd10, 0, 0, 6'd0, 2'b00, 0);
        chk("rst_rd_gnt", disp_gnt, 1);
        drive(0, 1, 6'd10, 1, 0, 6'd4, 2'b00, 0);
        chk("rst_mid_valid", disp_valid, 0);
        chk("rst_mid_gnt", disp_gnt | game_gnt, 0);
        chk("rst_mid_rdata", disp_rdata, 0);
        chk("rst_mid_addr", mem_addr, 0);
        drive(0, 0, 6'd0, 0, 0, 6'd0, 2'b00, 0);
        idle();
        chk("rst_after_valid", disp_valid, 0);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
